instruction_decode_pipe: RTL and testbench
==========================================

Name: instruction_decode_pipe

Overview:
- Next-generation decode stage: the same RV32I/RV64I field decode (imm, funct_alu, rdsel, decoded_op), now with an elastic valid/ready handshake on both sides instead of a global phase enable.
- Adds a 2-entry skid buffer, a real load-use interlock driving stall_decode, and a flush input.
- Sits between fetch and execute; the register_file is read combinationally through rs1sel/rs2sel.

Parameters:
- XLEN, 32: datapath width; 32 or 64.
- OPLEN, from core_general.vh: decoded_op width.
- SKID_DEPTH, 2: output buffer entries; legal values 1 or 2.

Ports:
- clk  in  1  CPU clock.
- rst_n  in  1  async reset, active-low; the polarity and synchronicity are fixed.
- inst  in  32  fetched instruction.
- inst_valid  in  1  fetch holds valid data.
- inst_ready  out  1  decode accepts this cycle.
- curr_pc_fd  in  XLEN  PC of inst.
- next_pc_fd  in  XLEN  next PC.
- rs1sel  out  5  combinational register_file select; 0 for LUI.
- rs2sel  out  5  combinational register_file select.
- rs1data_rd  in  XLEN  register_file read data 1.
- rs2data_rd  in  XLEN  register_file read data 2.
- ld_done  in  1  pulse: outstanding load has written back.
- flush  in  1  discard all buffered/decoded instructions.
- out_valid  out  1  head entry valid.
- out_ready  in  1  execute consumes the head.
- imm  out  XLEN  sign-extended immediate.
- rs1data_de  out  XLEN  registered operand 1.
- rs2data_de  out  XLEN  registered operand 2.
- curr_pc_de  out  XLEN  registered PC.
- next_pc_de  out  XLEN  registered next PC.
- funct_alu  out  4  {funct7[5],funct3}; forced 0 for BRANCH/AUIPC.
- rdsel_de  out  5  destination register; 0 for STORE/BRANCH.
- decoded_op_de  out  OPLEN  use_rs1/use_rs2/rd_sel/funct3/jump_en/mem_we.
- stall_decode  out  1  load-use interlock active.
- illegal_inst  out  1  head entry has an unknown opcode (see Optional Feature).

Behaviour:
- Reset values:
  - out_valid=0, stall_decode=0, illegal_inst=0, ld_pending=0.
  - All data outputs 0; skid buffer empty, pointers 0.
- Field decode is identical to the existing stage:
  - imm formats U/J/I/B/S.
  - funct7 is zeroed except for OP and OP_IMM shifts.
  - funct3 is forced to FUNCT3_JUMP for JAL/JALR.
  - rd_data_sel: PC for JAL/JALR, MEMORY for LOAD, COMP for SLT/SLTU OP_IMM, otherwise ALU.
- Accept: inst_ready = !full && !stall_decode && !flush. A transfer happens when inst_valid && inst_ready.
- Latency: on transfer, the decoded entry (including rs1data_rd/rs2data_rd sampled that cycle) is written at the edge; out_valid rises the next cycle. Minimum latency is 1 cycle.
- Buffer behaviour:
  - The head is presented on the outputs.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - Full: inst_ready=0. Empty: out_valid=0.
  - Head outputs stay stable while out_valid && !out_ready.
- Load-use interlock:
  - ld_pending is set with ld_rd = rd when a LOAD with rd != 0 is transferred.
  - ld_pending is cleared at the edge after ld_done.
  - stall_decode = inst_valid && ld_pending && ((use_rs1 data && rs1sel==ld_rd) || (use_rs2 data && rs2sel==ld_rd)).
  - x0 never matches.
  - If ld_done is asserted in the same cycle as a match, the stall still applies that cycle; the instruction is accepted the following cycle.
  - A second LOAD issued while ld_pending=1 overwrites ld_rd; loads complete in order.
- Flush:
  - At the edge, flush empties the buffer; out_valid=0 next cycle.
  - inst_ready=0 during the flush cycle.
  - ld_pending is NOT cleared, because a load already sent to memory completes.
- Reset mid-operation: everything returns to the reset values asynchronously; the in-flight entry is lost.

Optional Feature:
- Macro: DECODE_ILLEGAL_TRAP_EN.
- When defined:
  - An opcode outside {LUI,AUIPC,JAL,JALR,BRANCH,LOAD,STORE,OP_IMM,OP,MISC_MEM,SYSTEM}, or inst[1:0] != 2'b11, stores illegal=1 in the entry.
  - For that entry, decoded_op jump_en=0, mem_we=0 and rdsel_de=0.
  - illegal_inst follows the head entry.
- When undefined: illegal_inst is tied 0 and unknown opcodes decode to don't-care as before.

Decomposition:
- core_general.vh holds:
  - the opcode constants;
  - the decoded_op bit positions (USE_RS1_BIT, USE_RD_BIT_M/L, FUNCT3_BIT_M/L, JUMP_EN_BIT, DATA_MEM_WE_BIT);
  - the USE_* encodings and FUNCT3_JUMP.
- Sub-module decode_fields: purely combinational inst -> imm/funct_alu/rd_sel/decoded_op/illegal/use flags.
- The top level holds the skid buffer, the interlock and the handshake.

Test Plan:
- ADDI x5,x1,-1 (0xFFF08293), out_ready=1 -> next cycle out_valid=1, imm=0xFFFFFFFF, rdsel_de=5, funct_alu=0.
- out_ready=0 while 3 instructions are offered -> 2 accepted, then inst_ready=0. Outputs stay stable; release drains them in order.
- LW x3,0(x2) then ADD x4,x3,x1 -> stall_decode=1 and inst_ready=0 until ld_done. The ADD is accepted on the cycle after the ld_done edge.
- LW x0 followed by a consumer of x0 -> no stall.
- flush with 2 entries buffered -> out_valid=0 next cycle, and ld_pending survives.
- With DECODE_ILLEGAL_TRAP_EN, inst=0x00000000 -> illegal_inst=1 and rdsel_de=0. Without the macro -> illegal_inst=0.
- Assert rst_n low while out_valid=1 -> all outputs return to 0 immediately.

Source files
------------

// File: rtl/instruction_decode_pipe_pkg.sv
// instruction_decode_pipe_pkg: opcodes, decoded_op layout and decode bundle.
// Shared by the decode stage and its field decoder.
package instruction_decode_pipe_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam int USE_RS1_BIT     = 0;
  localparam int USE_RS2_BIT     = 1;
  localparam int USE_RD_BIT_L    = 2;
  localparam int USE_RD_BIT_M    = 3;
  localparam int FUNCT3_BIT_L    = 4;
  localparam int FUNCT3_BIT_M    = 6;
  localparam int JUMP_EN_BIT     = 7;
  localparam int DATA_MEM_WE_BIT = 8;
  localparam int OPLEN           = 9;

  localparam logic [1:0] USE_ALU    = 2'd0;
  localparam logic [1:0] USE_COMP   = 2'd1;
  localparam logic [1:0] USE_MEMORY = 2'd2;
  localparam logic [1:0] USE_PC     = 2'd3;

  localparam logic [2:0] FUNCT3_JUMP = 3'b010;

  typedef struct packed {
    logic [3:0]       funct_alu;
    logic [4:0]       rdsel;
    logic [OPLEN-1:0] op;
    logic             illegal;
  } dec_t;

endpackage

// File: rtl/instruction_decode_pipe_decode_fields.sv
// instruction_decode_pipe_decode_fields: combinational RV32I/RV64I field decode.
// DECODE_ILLEGAL_TRAP_EN marks unknown opcodes illegal and squashes side effects.
module instruction_decode_pipe_decode_fields
  import instruction_decode_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rs1sel,
  output logic [4:0]      rs2sel,
  output dec_t            dec
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [2:0]  f3_eff;
  logic [31:0] imm32;
  logic        is_lui, is_auipc, is_jal, is_jalr;
  logic        is_br, is_ld, is_st, is_opi;
  logic        is_op, is_fence, is_sys;
  logic        shamt, slt, f7b5;

  assign opc      = inst[6:0];
  assign f3       = inst[14:12];
  assign is_lui   = opc == OPC_LUI;
  assign is_auipc = opc == OPC_AUIPC;
  assign is_jal   = opc == OPC_JAL;
  assign is_jalr  = opc == OPC_JALR;
  assign is_br    = opc == OPC_BRANCH;
  assign is_ld    = opc == OPC_LOAD;
  assign is_st    = opc == OPC_STORE;
  assign is_opi   = opc == OPC_OP_IMM;
  assign is_op    = opc == OPC_OP;
  assign is_fence = opc == OPC_MISC_MEM;
  assign is_sys   = opc == OPC_SYSTEM;

  assign shamt  = is_opi && (f3 == 3'b001 || f3 == 3'b101);
  assign slt    = is_opi && (f3 == 3'b010 || f3 == 3'b011);
  assign f7b5   = (is_op || shamt) && inst[30];
  assign f3_eff = (is_jal || is_jalr) ? FUNCT3_JUMP : f3;
  assign rs1sel = is_lui ? 5'd0 : inst[19:15];
  assign rs2sel = inst[24:20];
  assign imm    = XLEN'(signed'(imm32));

  // immediate format select
  always_comb begin
    imm32 = '0;
    unique case (1'b1)
      is_lui, is_auipc:
        imm32 = {inst[31:12], 12'b0};
      is_jal:
        imm32 = {{12{inst[31]}}, inst[19:12],
                 inst[20], inst[30:21], 1'b0};
      is_jalr, is_ld, is_opi, is_fence, is_sys:
        imm32 = {{20{inst[31]}}, inst[31:20]};
      is_br:
        imm32 = {{20{inst[31]}}, inst[7],
                 inst[30:25], inst[11:8], 1'b0};
      is_st:
        imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      default:
        imm32 = '0;
    endcase
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic legal;
  assign legal = is_lui | is_auipc | is_jal | is_jalr
               | is_br | is_ld | is_st | is_opi
               | is_op | is_fence | is_sys;
`endif

  // control bundle: operand use, writeback source, side effects
  always_comb begin
    dec = '0;
    dec.op[USE_RS1_BIT] = is_jalr | is_br | is_ld
                        | is_st | is_opi | is_op;
    dec.op[USE_RS2_BIT] = is_br | is_st | is_op;
    dec.op[FUNCT3_BIT_M:FUNCT3_BIT_L] = f3_eff;
    dec.op[JUMP_EN_BIT] = is_jal | is_jalr | is_br;
    dec.op[DATA_MEM_WE_BIT] = is_st;
    unique case (1'b1)
      is_jal, is_jalr: dec.op[USE_RD_BIT_M:USE_RD_BIT_L] = USE_PC;
      is_ld:           dec.op[USE_RD_BIT_M:USE_RD_BIT_L] = USE_MEMORY;
      slt:             dec.op[USE_RD_BIT_M:USE_RD_BIT_L] = USE_COMP;
      default:         dec.op[USE_RD_BIT_M:USE_RD_BIT_L] = USE_ALU;
    endcase
    dec.funct_alu = (is_br || is_auipc) ? 4'd0 : {f7b5, f3_eff};
    dec.rdsel = (is_st || is_br) ? 5'd0 : inst[11:7];
`ifdef DECODE_ILLEGAL_TRAP_EN
    dec.illegal = !legal;
    if (!legal) begin
      dec.rdsel = 5'd0;
      dec.op[JUMP_EN_BIT] = 1'b0;
      dec.op[DATA_MEM_WE_BIT] = 1'b0;
    end
`else
    dec.illegal = 1'b0;
`endif
  end

endmodule

// File: rtl/instruction_decode_pipe.sv
// instruction_decode_pipe: elastic decode stage with skid buffer and load-use interlock.
// DECODE_ILLEGAL_TRAP_EN enables illegal-opcode flagging on the head entry.
module instruction_decode_pipe
  import instruction_decode_pipe_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SKID_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      inst,
  input  logic             inst_valid,
  output logic             inst_ready,
  input  logic [XLEN-1:0]  curr_pc_fd,
  input  logic [XLEN-1:0]  next_pc_fd,
  output logic [4:0]       rs1sel,
  output logic [4:0]       rs2sel,
  input  logic [XLEN-1:0]  rs1data_rd,
  input  logic [XLEN-1:0]  rs2data_rd,
  input  logic             ld_done,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic [XLEN-1:0]  rs1data_de,
  output logic [XLEN-1:0]  rs2data_de,
  output logic [XLEN-1:0]  curr_pc_de,
  output logic [XLEN-1:0]  next_pc_de,
  output logic [3:0]       funct_alu,
  output logic [4:0]       rdsel_de,
  output logic [OPLEN-1:0] decoded_op_de,
  output logic             stall_decode,
  output logic             illegal_inst
);

  typedef struct packed {
    dec_t            dec;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
  } id_ex_t;

  localparam logic [1:0] DEPTH = 2'(SKID_DEPTH);

  dec_t            dec;
  logic [XLEN-1:0] dec_imm;
  id_ex_t          entry;
  id_ex_t          head;
  id_ex_t          mem [SKID_DEPTH];
  logic [1:0]      count;
  logic            wr_ptr, rd_ptr;
  logic            full, push, pop, is_ld;
  logic            hit1, hit2;
  logic            ld_pending;
  logic [4:0]      ld_rd;

  function automatic logic nxt(input logic p);
    return (SKID_DEPTH == 1) ? 1'b0 : ~p;
  endfunction

  instruction_decode_pipe_decode_fields #(
    .XLEN(XLEN)
  ) u_fields (
    .inst  (inst),
    .imm   (dec_imm),
    .rs1sel(rs1sel),
    .rs2sel(rs2sel),
    .dec   (dec)
  );

  assign entry = '{dec: dec, imm: dec_imm,
                   rs1: rs1data_rd, rs2: rs2data_rd,
                   pc: curr_pc_fd, npc: next_pc_fd};

  assign is_ld = dec.op[USE_RD_BIT_M:USE_RD_BIT_L] == USE_MEMORY;
  assign hit1  = dec.op[USE_RS1_BIT] && rs1sel != 5'd0
              && rs1sel == ld_rd;
  assign hit2  = dec.op[USE_RS2_BIT] && rs2sel != 5'd0
              && rs2sel == ld_rd;

  assign stall_decode = inst_valid && ld_pending && (hit1 || hit2);
  assign full         = count == DEPTH;
  assign inst_ready   = !full && !stall_decode && !flush;
  assign push         = inst_valid && inst_ready;
  assign out_valid    = count != 2'd0;
  assign pop          = out_valid && out_ready;

  // skid buffer: write at tail, present head, flush empties
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= entry;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // load-use tracking; survives flush since the load is already issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_pending <= 1'b0;
      ld_rd      <= 5'd0;
    end else if (push && is_ld && dec.rdsel != 5'd0) begin
      ld_pending <= 1'b1;
      ld_rd      <= dec.rdsel;
    end else if (ld_done) begin
      ld_pending <= 1'b0;
    end
  end

  assign head          = mem[rd_ptr];
  assign imm           = head.imm;
  assign rs1data_de    = head.rs1;
  assign rs2data_de    = head.rs2;
  assign curr_pc_de    = head.pc;
  assign next_pc_de    = head.npc;
  assign funct_alu     = head.dec.funct_alu;
  assign rdsel_de      = head.dec.rdsel;
  assign decoded_op_de = head.dec.op;
  assign illegal_inst  = out_valid && head.dec.illegal;

endmodule

// File: tb/tb_instruction_decode_pipe.sv
// tb_instruction_decode_pipe: randomized and directed checks against a queue model.
// Build with DECODE_ILLEGAL_TRAP_EN to cover illegal-opcode flagging.
module tb_instruction_decode_pipe;
  import instruction_decode_pipe_pkg::*;

  localparam int XLEN = 32;
`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [31:0]      inst;
  logic             inst_valid, inst_ready;
  logic [XLEN-1:0]  curr_pc_fd, next_pc_fd;
  logic [4:0]       rs1sel, rs2sel;
  logic [XLEN-1:0]  rs1data_rd, rs2data_rd;
  logic             ld_done, flush, out_valid, out_ready;
  logic [XLEN-1:0]  imm, rs1data_de, rs2data_de;
  logic [XLEN-1:0]  curr_pc_de, next_pc_de;
  logic [3:0]       funct_alu;
  logic [4:0]       rdsel_de;
  logic [OPLEN-1:0] decoded_op_de;
  logic             stall_decode, illegal_inst;

  instruction_decode_pipe #(.XLEN(XLEN), .SKID_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .inst(inst),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .curr_pc_fd(curr_pc_fd), .next_pc_fd(next_pc_fd),
    .rs1sel(rs1sel), .rs2sel(rs2sel),
    .rs1data_rd(rs1data_rd), .rs2data_rd(rs2data_rd),
    .ld_done(ld_done), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .imm(imm), .rs1data_de(rs1data_de), .rs2data_de(rs2data_de),
    .curr_pc_de(curr_pc_de), .next_pc_de(next_pc_de),
    .funct_alu(funct_alu), .rdsel_de(rdsel_de),
    .decoded_op_de(decoded_op_de),
    .stall_decode(stall_decode), .illegal_inst(illegal_inst)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      imm;
    logic [3:0]       falu;
    logic [4:0]       rd;
    logic [OPLEN-1:0] op;
    logic             ill, dc, u1, u2, ld;
    logic [31:0]      a, b, pc, npc;
  } exp_t;

  exp_t       q[$];
  logic       pend;
  logic [4:0] pend_rd;
  int         n_vec, n_bad;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model_dec(input logic [31:0] i);
    exp_t        e;
    logic [6:0]  o;
    logic [2:0]  f3;
    logic [12:0] tb;
    logic [20:0] tj;
    logic [1:0]  src;
    logic        f7, jmp, we, legal;
    int          v;
    e = '{default: 0};
    o = i[6:0];
    f3 = i[14:12];
    tb = {i[31], i[7], i[30:25], i[11:8], 1'b0};
    tj = {i[31], i[19:12], i[20], i[30:21], 1'b0};
    v = 0; f7 = 0; jmp = 0; we = 0; legal = 1; src = USE_ALU;
    e.rd = i[11:7];
    case (o)
      OPC_LUI, OPC_AUIPC: v = int'(i & 32'hFFFFF000);
      OPC_JAL: begin
        v = int'($signed(tj)); jmp = 1; src = USE_PC; f3 = FUNCT3_JUMP;
      end
      OPC_JALR: begin
        v = int'($signed(i)) >>> 20; e.u1 = 1; jmp = 1;
        src = USE_PC; f3 = FUNCT3_JUMP;
      end
      OPC_BRANCH: begin
        v = int'($signed(tb)); e.u1 = 1; e.u2 = 1; jmp = 1; e.rd = 0;
      end
      OPC_LOAD: begin
        v = int'($signed(i)) >>> 20; e.u1 = 1; src = USE_MEMORY; e.ld = 1;
      end
      OPC_STORE: begin
        v = (int'($signed(i)) >>> 25) * 32 + int'(i[11:7]);
        e.u1 = 1; e.u2 = 1; we = 1; e.rd = 0;
      end
      OPC_OP_IMM: begin
        v = int'($signed(i)) >>> 20; e.u1 = 1;
        if (f3 == 3'd1 || f3 == 3'd5) f7 = i[30];
        if (f3 == 3'd2 || f3 == 3'd3) src = USE_COMP;
      end
      OPC_OP: begin
        v = 0; e.u1 = 1; e.u2 = 1; f7 = i[30];
      end
      OPC_MISC_MEM, OPC_SYSTEM: v = int'($signed(i)) >>> 20;
      default: legal = 0;
    endcase
    e.imm = 32'(v);
    e.falu = (o == OPC_BRANCH || o == OPC_AUIPC) ? 4'd0 : {f7, f3};
    e.op = '0;
    e.op[USE_RS1_BIT] = e.u1;
    e.op[USE_RS2_BIT] = e.u2;
    e.op[USE_RD_BIT_M:USE_RD_BIT_L] = src;
    e.op[FUNCT3_BIT_M:FUNCT3_BIT_L] = f3;
    e.op[JUMP_EN_BIT] = jmp;
    e.op[DATA_MEM_WE_BIT] = we;
    if (!legal) begin
      if (TRAP) begin
        e.ill = 1; e.rd = 0;
      end else begin
        e.dc = 1;
      end
    end
    return e;
  endfunction

  task automatic step();
    exp_t       d;
    logic [4:0] r1;
    logic       stl, rdy, popm, push;
    @(negedge clk);
    d = model_dec(inst);
    r1 = (inst[6:0] == OPC_LUI) ? 5'd0 : inst[19:15];
    stl = inst_valid && pend &&
          ((d.u1 && r1 != 0 && r1 == pend_rd) ||
           (d.u2 && inst[24:20] != 0 && inst[24:20] == pend_rd));
    rdy = (q.size() < 2) && !stl && !flush;
    chk("rs1sel", rs1sel, r1);
    chk("rs2sel", rs2sel, inst[24:20]);
    chk("stall", stall_decode, stl);
    chk("inst_ready", inst_ready, rdy);
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("illegal", illegal_inst, q[0].ill);
      chk("rs1data_de", rs1data_de, q[0].a);
      chk("rs2data_de", rs2data_de, q[0].b);
      chk("curr_pc_de", curr_pc_de, q[0].pc);
      chk("next_pc_de", next_pc_de, q[0].npc);
      if (!q[0].dc) begin
        chk("imm", imm, q[0].imm);
        chk("funct_alu", funct_alu, q[0].falu);
        chk("rdsel_de", rdsel_de, q[0].rd);
        chk("decoded_op", decoded_op_de, q[0].op);
      end
    end else begin
      chk("illegal_idle", illegal_inst, 1'b0);
    end
    popm = q.size() != 0 && out_ready;
    push = inst_valid && rdy;
    if (flush) begin
      q.delete();
    end else begin
      if (popm) void'(q.pop_front());
      if (push) begin
        d.a = rs1data_rd; d.b = rs2data_rd;
        d.pc = curr_pc_fd; d.npc = next_pc_fd;
        q.push_back(d);
      end
    end
    if (push && d.ld && inst[11:7] != 0) begin
      pend = 1; pend_rd = inst[11:7];
    end else if (ld_done) begin
      pend = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    logic [6:0]  ops [11];
    logic [31:0] w;
    ops = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
            OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP,
            OPC_MISC_MEM, OPC_SYSTEM};
    w = $urandom;
    w[6:0] = ops[$urandom_range(0, 10)];
    if (TRAP && $urandom_range(0, 19) == 0) w[1:0] = 2'b00;
    w[11:7]  = 5'($urandom_range(0, 4));
    w[19:15] = 5'($urandom_range(0, 4));
    w[24:20] = 5'($urandom_range(0, 4));
    inst       = w;
    inst_valid = $urandom_range(0, 3) != 0;
    out_ready  = 1'($urandom_range(0, 1));
    ld_done    = $urandom_range(0, 3) == 0;
    flush      = $urandom_range(0, 15) == 0;
    rs1data_rd = $urandom;
    rs2data_rd = $urandom;
    curr_pc_fd = $urandom;
    next_pc_fd = $urandom;
  endtask

  initial begin
    n_vec = 0; n_bad = 0; pend = 0; pend_rd = 0;
    inst = 0; inst_valid = 0; out_ready = 0;
    ld_done = 0; flush = 0;
    rs1data_rd = 32'h1111_0001; rs2data_rd = 32'h2222_0002;
    curr_pc_fd = 32'h0000_1000; next_pc_fd = 32'h0000_1004;
    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_stall", stall_decode, 1'b0);
    chk("rst_illegal", illegal_inst, 1'b0);
    chk("rst_imm", imm, 32'd0);
    chk("rst_rdsel", rdsel_de, 5'd0);
    chk("rst_op", decoded_op_de, '0);
    chk("rst_next_pc", next_pc_de, 32'd0);
    @(posedge clk); #1;
    rst_n = 1;

    // ADDI x5,x1,-1
    inst = 32'hFFF08293; inst_valid = 1; out_ready = 1;
    step();
    inst_valid = 0;
    #3;
    chk("addi_valid", out_valid, 1'b1);
    chk("addi_imm", imm, 32'hFFFFFFFF);
    chk("addi_rd", rdsel_de, 5'd5);
    chk("addi_falu", funct_alu, 4'd0);
    step();

    // back-pressure: three offered, two held
    out_ready = 0; inst_valid = 1;
    inst = 32'h00500093; curr_pc_fd = 32'h2000; step();
    inst = 32'h0FF16113; curr_pc_fd = 32'h2004; step();
    inst = 32'h40208233; curr_pc_fd = 32'h2008;
    #3;
    chk("full_ready", inst_ready, 1'b0);
    step();
    step();
    inst_valid = 0; out_ready = 1;
    step(); step(); step();

    // load-use interlock
    inst = 32'h00012183; inst_valid = 1; step();
    inst = 32'h00118233;
    #3;
    chk("lu_stall", stall_decode, 1'b1);
    chk("lu_ready", inst_ready, 1'b0);
    step(); step();
    ld_done = 1;
    #3;
    chk("lu_stall_done", stall_decode, 1'b1);
    step();
    ld_done = 0;
    #3;
    chk("lu_release", inst_ready, 1'b1);
    step();
    inst_valid = 0; step(); step();

    // load to x0 never interlocks
    inst = 32'h00012003; inst_valid = 1; step();
    inst = 32'h00100233;
    #3;
    chk("x0_nostall", stall_decode, 1'b0);
    step();
    inst_valid = 0; step();

    // flush with two buffered, load still pending
    out_ready = 0; inst_valid = 1;
    inst = 32'h00012183; step();
    inst = 32'hFFF08293; step();
    flush = 1;
    #3;
    chk("flush_ready", inst_ready, 1'b0);
    step();
    flush = 0; inst = 32'h00118233;
    #3;
    chk("flush_empty", out_valid, 1'b0);
    chk("flush_pend", stall_decode, 1'b1);
    step();
    ld_done = 1; step();
    ld_done = 0; step();
    inst_valid = 0; out_ready = 1; step(); step();

    // all-zero word is not a legal opcode
    inst = 32'h00000000; inst_valid = 1; step();
    inst_valid = 0;
    #3;
    chk("zero_illegal", illegal_inst, TRAP);
    chk("zero_rd", rdsel_de, 5'd0);
    step();

    for (int n = 0; n < 600; n++) begin
      rand_inputs();
      step();
    end

    // asynchronous reset while holding a valid head
    inst_valid = 0; ld_done = 1; flush = 1; step();
    ld_done = 0; flush = 0; out_ready = 0;
    inst = 32'hFFF08293; inst_valid = 1;
    rs1data_rd = 32'hDEAD_BEEF; curr_pc_fd = 32'h3000;
    step(); step();
    #2;
    chk("pre_rst_valid", out_valid, 1'b1);
    rst_n = 0;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_imm", imm, 32'd0);
    chk("arst_rd", rdsel_de, 5'd0);
    chk("arst_rs1", rs1data_de, 32'd0);
    chk("arst_pc", curr_pc_de, 32'd0);
    chk("arst_falu", funct_alu, 4'd0);
    chk("arst_op", decoded_op_de, '0);
    chk("arst_stall", stall_decode, 1'b0);
    q.delete(); pend = 0; inst_valid = 0;
    @(posedge clk); #1;
    rst_n = 1;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
